serial_adder: RTL and testbench

- Bit-serial adder built around the team's full-adder cell: one sum bit and one carry per clock, LSB first.
- Adds two WIDTH-bit operands plus a carry-in, trading latency for a single full-adder slice.
- Sits downstream of operand registers and upstream of any consumer using a start/done handshake.
- Used where area matters more than throughput.

---
 rtl/serial_adder_if.sv | 24 ++
 rtl/serial_adder.sv | 96 +++++++++
 tb/tb_serial_adder.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/serial_adder_if.sv
// Start/done handshake bundle between an operand source and the serial adder.
// The master drives operands and start; the slave returns busy/done and the result.
interface serial_adder_if #(
  parameter int WIDTH = 8
) ();
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (
    output start, a, b, cin,
    input  busy, done, sum, cout
  );

  modport slave (
    input  start, a, b, cin,
    output busy, done, sum, cout
  );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder slice processes one bit per clock, LSB first.
// state | meaning
// IDLE  | waiting for start; result registers hold the last completed sum
// RUN   | one bit per edge through the slice; busy high
// DONE  | one-cycle done pulse; start here launches the next add directly
module serial_adder #(
  parameter int WIDTH = 8
) (
  input logic          clk,
  input logic          rst,
  serial_adder_if.slave bus
);
  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [WIDTH-1:0] ps;
  logic             carry;
  logic [CNT_W-1:0] cnt;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;

  logic             fa_s;
  logic             fa_co;
  logic [WIDTH-1:0] ps_next;

  always_comb begin
    fa_s    = sa[0] ^ sb[0] ^ carry;
    fa_co   = (sa[0] & sb[0]) | (sa[0] & carry) | (sb[0] & carry);
    ps_next = {fa_s, ps[WIDTH-1:1]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      sa     <= '0;
      sb     <= '0;
      ps     <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      sum_q  <= '0;
      cout_q <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            sa     <= bus.a;
            sb     <= bus.b;
            carry  <= bus.cin;
            ps     <= '0;
            cnt    <= '0;
            busy_q <= 1'b1;
            state  <= RUN;
          end else begin
            busy_q <= 1'b0;
            state  <= IDLE;
          end
        end
        RUN: begin
          ps    <= ps_next;
          sa    <= sa >> 1;
          sb    <= sb >> 1;
          carry <= fa_co;
          cnt   <= cnt + 1'b1;
          // Last bit: publish the result straight from the slice outputs.
          if (cnt == LAST) begin
            sum_q  <= ps_next;
            cout_q <= fa_co;
            busy_q <= 1'b0;
            done_q <= 1'b1;
            state  <= DONE;
          end
        end
        default: begin
          busy_q <= 1'b0;
          done_q <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: 8-bit directed scenarios plus exhaustive 4-bit.
module tb_serial_adder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  serial_adder_if #(.WIDTH(8)) if8 ();
  serial_adder_if #(.WIDTH(4)) if4 ();

  serial_adder #(.WIDTH(8)) u8 (.clk(clk), .rst(rst), .bus(if8.slave));
  serial_adder #(.WIDTH(4)) u4 (.clk(clk), .rst(rst), .bus(if4.slave));

  int n_checks = 0;
  int n_pass   = 0;
  logic [8:0] q8[$];
  logic [4:0] q4[$];

  // Waits (bounded) for done on the 8-bit DUT, counting busy cycles and watching result hold.
  task automatic wait_done8(output int cyc, output int busy_cnt, output bit held);
    logic [7:0] s0;
    logic       c0;
    s0 = if8.sum; c0 = if8.cout;
    cyc = 0; busy_cnt = 0; held = 1'b1;
    while (if8.done !== 1'b1 && cyc < 40) begin
      if (if8.busy === 1'b1) busy_cnt++;
      if (if8.sum !== s0 || if8.cout !== c0) held = 1'b0;
      @(negedge clk);
      cyc++;
    end
  endtask

  // Drives a one-cycle start on the 8-bit DUT and records the expected result.
  task automatic launch8(input logic [7:0] a, input logic [7:0] b, input logic cin);
    if8.a = a; if8.b = b; if8.cin = cin; if8.start = 1'b1;
    q8.push_back(9'(a) + 9'(b) + 9'(cin));
    @(negedge clk);
    if8.start = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    if8.start = 1'b0; if8.a = '0; if8.b = '0; if8.cin = 1'b0;
    if4.start = 1'b0; if4.a = '0; if4.b = '0; if4.cin = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_checks++; if (if8.busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", if8.busy); else n_pass++;
    n_checks++; if (if8.done !== 1'b0) $display("FAIL reset_done: got %b want 0", if8.done); else n_pass++;
    n_checks++; if (if8.sum !== 8'h00) $display("FAIL reset_sum: got %h want 00", if8.sum); else n_pass++;
    n_checks++; if (if8.cout !== 1'b0) $display("FAIL reset_cout: got %b want 0", if8.cout); else n_pass++;
  endtask

  task automatic test_basic;
    int cyc, bc; bit held;
    logic [8:0] exp;
    launch8(8'h3C, 8'h5A, 1'b0);
    n_checks++; if (if8.busy !== 1'b1) $display("FAIL basic_busy_rise: got %b want 1", if8.busy); else n_pass++;
    wait_done8(cyc, bc, held);
    exp = q8.pop_front();
    n_checks++; if (cyc != 8) $display("FAIL basic_latency: got %0d want 8", cyc); else n_pass++;
    n_checks++; if (bc != 8) $display("FAIL basic_busy_cycles: got %0d want 8", bc); else n_pass++;
    n_checks++; if (!held) $display("FAIL basic_result_hold: got changed want held"); else n_pass++;
    n_checks++; if ({if8.cout, if8.sum} !== exp) $display("FAIL basic_sum: got %h want %h", {if8.cout, if8.sum}, exp); else n_pass++;
    n_checks++; if (exp !== 9'h096) $display("FAIL basic_model: got %h want 096", exp); else n_pass++;
    @(negedge clk);
    n_checks++; if (if8.done !== 1'b0) $display("FAIL basic_done_pulse: got %b want 0", if8.done); else n_pass++;
    n_checks++; if (if8.sum !== 8'h96) $display("FAIL basic_sum_hold_idle: got %h want 96", if8.sum); else n_pass++;
  endtask

  task automatic test_carry;
    int cyc, bc; bit held;
    logic [8:0] exp;
    launch8(8'hFF, 8'h01, 1'b0);
    wait_done8(cyc, bc, held);
    exp = q8.pop_front();
    n_checks++; if ({if8.cout, if8.sum} !== exp) $display("FAIL carry_ff_01: got %h want %h", {if8.cout, if8.sum}, exp); else n_pass++;
    @(negedge clk);
    launch8(8'hFF, 8'hFF, 1'b1);
    wait_done8(cyc, bc, held);
    exp = q8.pop_front();
    n_checks++; if ({if8.cout, if8.sum} !== exp) $display("FAIL carry_ff_ff_1: got %h want %h", {if8.cout, if8.sum}, exp); else n_pass++;
    n_checks++; if (!held) $display("FAIL carry_result_hold: got changed want held"); else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_start_ignored;
    int cyc, bc, extra; bit held;
    logic [8:0] exp;
    launch8(8'h01, 8'h01, 1'b0);
    repeat (2) @(negedge clk);
    if8.a = 8'h80; if8.b = 8'h80; if8.start = 1'b1;
    @(negedge clk);
    if8.start = 1'b0;
    wait_done8(cyc, bc, held);
    exp = q8.pop_front();
    n_checks++; if (cyc != 5) $display("FAIL ignore_latency: got %0d want 5", cyc); else n_pass++;
    n_checks++; if ({if8.cout, if8.sum} !== exp) $display("FAIL ignore_sum: got %h want %h", {if8.cout, if8.sum}, exp); else n_pass++;
    extra = 0;
    repeat (12) begin
      @(negedge clk);
      if (if8.done === 1'b1) extra++;
    end
    n_checks++; if (extra != 0) $display("FAIL ignore_single_done: got %0d extra want 0", extra); else n_pass++;
  endtask

  task automatic test_back_to_back;
    int cyc, bc; bit held;
    logic [8:0] exp;
    if8.a = 8'h10; if8.b = 8'h20; if8.cin = 1'b0; if8.start = 1'b1;
    q8.push_back(9'h030);
    @(negedge clk);
    wait_done8(cyc, bc, held);
    exp = q8.pop_front();
    n_checks++; if ({if8.cout, if8.sum} !== exp) $display("FAIL b2b_first_sum: got %h want %h", {if8.cout, if8.sum}, exp); else n_pass++;
    n_checks++; if (if8.busy !== 1'b0) $display("FAIL b2b_busy_in_done: got %b want 0", if8.busy); else n_pass++;
    if8.a = 8'h7F; if8.b = 8'h01;
    q8.push_back(9'h080);
    @(negedge clk);
    if8.start = 1'b0;
    n_checks++; if (if8.busy !== 1'b1) $display("FAIL b2b_rerun: got %b want 1", if8.busy); else n_pass++;
    wait_done8(cyc, bc, held);
    exp = q8.pop_front();
    n_checks++; if (cyc != 8 || bc != 8) $display("FAIL b2b_second_latency: got %0d/%0d want 8/8", cyc, bc); else n_pass++;
    n_checks++; if (!held) $display("FAIL b2b_hold_first: got changed want held"); else n_pass++;
    n_checks++; if ({if8.cout, if8.sum} !== exp) $display("FAIL b2b_second_sum: got %h want %h", {if8.cout, if8.sum}, exp); else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    int extra;
    if8.a = 8'hAA; if8.b = 8'h55; if8.cin = 1'b0; if8.start = 1'b1;
    @(negedge clk);
    if8.start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_checks++; if (if8.busy !== 1'b0) $display("FAIL rstmid_busy: got %b want 0", if8.busy); else n_pass++;
    n_checks++; if (if8.done !== 1'b0) $display("FAIL rstmid_done: got %b want 0", if8.done); else n_pass++;
    n_checks++; if (if8.sum !== 8'h00) $display("FAIL rstmid_sum: got %h want 00", if8.sum); else n_pass++;
    n_checks++; if (if8.cout !== 1'b0) $display("FAIL rstmid_cout: got %b want 0", if8.cout); else n_pass++;
    extra = 0;
    repeat (12) begin
      @(negedge clk);
      if (if8.done === 1'b1 || if8.busy === 1'b1) extra++;
    end
    n_checks++; if (extra != 0) $display("FAIL rstmid_quiet: got %0d active cycles want 0", extra); else n_pass++;
  endtask

  task automatic test_exhaustive4;
    int cyc;
    logic [4:0] exp;
    for (int ci = 0; ci < 2; ci++) begin
      for (int ai = 0; ai < 16; ai++) begin
        for (int bi = 0; bi < 16; bi++) begin
          if4.a = 4'(ai); if4.b = 4'(bi); if4.cin = 1'(ci); if4.start = 1'b1;
          q4.push_back(5'(ai) + 5'(bi) + 5'(ci));
          @(negedge clk);
          if4.start = 1'b0;
          cyc = 0;
          while (if4.done !== 1'b1 && cyc < 20) begin
            @(negedge clk);
            cyc++;
          end
          exp = q4.pop_front();
          n_checks++;
          if (cyc != 4 || {if4.cout, if4.sum} !== exp)
            $display("FAIL exh4 a=%h b=%h cin=%0d: got %h after %0d want %h after 4",
                     4'(ai), 4'(bi), ci, {if4.cout, if4.sum}, cyc, exp);
          else n_pass++;
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_carry();
    test_start_ignored();
    test_back_to_back();
    test_reset_mid();
    test_exhaustive4();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
